// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with a data-memory timeout and sticky trap.
// Optional macro CTRL_RETIRE_CNT_EN adds the instret retired-instruction counter output.
module multicycle_control_unit #(
  parameter int          ALUSEL_W    = 4,
  parameter int          MEM_TIMEOUT = 15,
  parameter logic [31:0] NOP_INS     = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         ins,
  input  logic                iready,
  input  logic                dready,
  input  logic                breq,
  input  logic                brlt,
  output logic                irwen,
  output logic                pcwen,
  output logic                pcsel,
  output logic                regwen,
  output logic                asel,
  output logic                bsel,
  output logic                brun,
  output logic                memr,
  output logic                memw,
  output logic [1:0]          wbsel,
  output logic [ALUSEL_W-1:0] alusel,
  output logic [2:0]          immsel,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [2:0]          state
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0]         instret
`endif
);

  // Handshakes: instruction accepted on any FETCH cycle with iready=1; a data
  // access completes on the first MEM cycle with dready=1 (memr/memw held until then).
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [ALUSEL_W-1:0] ALU_ADD  = ALUSEL_W'(0);
  localparam logic [ALUSEL_W-1:0] ALU_SUB  = ALUSEL_W'(1);
  localparam logic [ALUSEL_W-1:0] ALU_AND  = ALUSEL_W'(2);
  localparam logic [ALUSEL_W-1:0] ALU_OR   = ALUSEL_W'(3);
  localparam logic [ALUSEL_W-1:0] ALU_XOR  = ALUSEL_W'(4);
  localparam logic [ALUSEL_W-1:0] ALU_SLL  = ALUSEL_W'(5);
  localparam logic [ALUSEL_W-1:0] ALU_SRL  = ALUSEL_W'(6);
  localparam logic [ALUSEL_W-1:0] ALU_SRA  = ALUSEL_W'(7);
  localparam logic [ALUSEL_W-1:0] ALU_SLT  = ALUSEL_W'(8);
  localparam logic [ALUSEL_W-1:0] ALU_SLTU = ALUSEL_W'(9);
  localparam logic [ALUSEL_W-1:0] ALU_PASB = ALUSEL_W'(10);

  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_U = 3'd5;

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] ir;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ir;

  assign opcode    = ir[6:0];
  assign rd        = ir[11:7];
  assign funct3    = ir[14:12];
  assign funct7    = ir[31:25];
  assign unused_ir = ^ir[24:15];

  logic is_op, is_opimm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  assign is_op     = (opcode == 7'b0110011);
  assign is_opimm  = (opcode == 7'b0010011);
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_branch = (opcode == 7'b1100011);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111);
  assign is_lui    = (opcode == 7'b0110111);
  assign is_auipc  = (opcode == 7'b0010111);

  logic legal;
  always_comb begin
    legal = 1'b0;
    if (is_op)
      legal = (funct7 == 7'b0000000) ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
    else if (is_opimm) begin
      if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
      else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      else                       legal = 1'b1;
    end
    else if (is_load || is_store) legal = (funct3 == 3'b010);
    else if (is_branch)           legal = (funct3 != 3'b010) && (funct3 != 3'b011);
    else if (is_jalr)             legal = (funct3 == 3'b000);
    else if (is_jal || is_lui || is_auipc) legal = 1'b1;
  end

  // funct7[5] selects SUB only for register-register ops; for shifts it selects SRA.
  logic [ALUSEL_W-1:0] alu_fn;
  always_comb begin
    case (funct3)
      3'b000:  alu_fn = (is_op && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  end

  logic taken;
  always_comb begin
    case (funct3)
      3'b000:          taken = breq;
      3'b001:          taken = ~breq;
      3'b100, 3'b110:  taken = brlt;
      3'b101, 3'b111:  taken = ~brlt;
      default:         taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    irwen   = 1'b0;
    pcwen   = 1'b0;
    pcsel   = 1'b0;
    regwen  = 1'b0;
    asel    = 1'b0;
    bsel    = 1'b0;
    brun    = 1'b0;
    memr    = 1'b0;
    memw    = 1'b0;
    wbsel   = 2'b00;
    alusel  = ALU_ADD;
    immsel  = 3'd0;

    // Datapath selects stay stable from EXEC through WB so the ALU result
    // (address, jump target, writeback value) does not change mid-instruction.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      if (is_op) begin
        asel = 1'b1; bsel = 1'b1; alusel = alu_fn;
      end else if (is_opimm) begin
        asel = 1'b1; immsel = IMM_I; alusel = alu_fn;
      end else if (is_load || is_jalr) begin
        asel = 1'b1; immsel = IMM_I;
      end else if (is_store) begin
        asel = 1'b1; immsel = IMM_S;
      end else if (is_branch) begin
        immsel = IMM_B; brun = funct3[1];
      end else if (is_jal) begin
        immsel = IMM_J;
      end else if (is_lui) begin
        immsel = IMM_U; alusel = ALU_PASB;
      end else if (is_auipc) begin
        immsel = IMM_U;
      end
    end

    case (state_q)
      S_FETCH: begin
        irwen = iready;
        if (iready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (legal) state_d = S_EXEC;
        else begin
          state_d = S_TRAP; trap_d = 1'b1; cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        tcnt_d = 8'd0;
        if (is_branch) begin
          pcwen = 1'b1; pcsel = taken; state_d = S_FETCH;
        end else if (is_load || is_store) state_d = S_MEM;
        else state_d = S_WB;
      end
      S_MEM: begin
        memr = is_load;
        memw = is_store;
        if (dready) begin
          if (is_store) begin
            pcwen = 1'b1; state_d = S_FETCH;
          end else state_d = S_WB;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
          if (tcnt_d == TIMEOUT_LIM) begin
            state_d = S_TRAP; trap_d = 1'b1; cause_d = 2'b10;
          end
        end
      end
      S_WB: begin
        regwen  = (rd != 5'd0);
        wbsel   = is_load ? 2'b00 : ((is_jal || is_jalr) ? 2'b11 : 2'b01);
        pcwen   = 1'b1;
        pcsel   = is_jal || is_jalr;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir      <= NOP_INS;
      tcnt_q  <= 8'd0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
      if (irwen) ir <= ins;
    end
  end

  assign state      = state_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] instret_q;
  always_ff @(posedge clk) begin
    if (rst)        instret_q <= 32'd0;
    else if (pcwen) instret_q <= instret_q + 32'd1;
  end
  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expected control vectors
// are queued by the driver and compared at the falling edge by a monitor.
module tb_multicycle_control_unit;

  localparam int W = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins;
  logic        iready, dready, breq, brlt;
  logic        irwen, pcwen, pcsel, regwen, asel, bsel, brun, memr, memw, trap;
  logic [1:0]  wbsel, trap_cause;
  logic [3:0]  alusel;
  logic [2:0]  immsel, state;
`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] instret;
`endif

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .ins(ins), .iready(iready), .dready(dready),
    .breq(breq), .brlt(brlt), .irwen(irwen), .pcwen(pcwen), .pcsel(pcsel),
    .regwen(regwen), .asel(asel), .bsel(bsel), .brun(brun), .memr(memr),
    .memw(memw), .wbsel(wbsel), .alusel(alusel), .immsel(immsel), .trap(trap),
    .trap_cause(trap_cause), .state(state)
`ifdef CTRL_RETIRE_CNT_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ret_cnt  = 0;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  // {irwen,pcwen,pcsel,regwen,memr,memw}
  localparam logic [5:0] EN_NONE = 6'b000000;
  localparam logic [5:0] EN_IR   = 6'b100000;
  localparam logic [5:0] EN_WB   = 6'b010100;
  localparam logic [5:0] EN_PC   = 6'b010000;
  localparam logic [5:0] EN_BRT  = 6'b011000;
  localparam logic [5:0] EN_JWB  = 6'b011100;
  localparam logic [5:0] EN_RD   = 6'b000010;
  localparam logic [5:0] EN_WR   = 6'b000001;
  // {asel,bsel,brun,alusel[3:0],immsel[2:0]}
  localparam logic [9:0] DP_NONE = 10'b0_0_0_0000_000;
  localparam logic [9:0] DP_ADD  = 10'b1_1_0_0000_000;
  localparam logic [9:0] DP_SUB  = 10'b1_1_0_0001_000;
  localparam logic [9:0] DP_LDI  = 10'b1_0_0_0000_001;
  localparam logic [9:0] DP_ST   = 10'b1_0_0_0000_010;
  localparam logic [9:0] DP_BEQ  = 10'b0_0_0_0000_011;
  localparam logic [9:0] DP_BLTU = 10'b0_0_1_0000_011;
  localparam logic [9:0] DP_JAL  = 10'b0_0_0_0000_100;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BLTU = 32'h0020E463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_ADDI = 32'h00100013;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  logic [W-1:0] obs;
  assign obs = {state, irwen, pcwen, pcsel, regwen, memr, memw, wbsel,
                trap, trap_cause, asel, bsel, brun, alusel, immsel};

  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [5:0] en,
                                      input logic [1:0] wb, input logic [2:0] tc,
                                      input logic [9:0] dp);
    return {st, en, wb, tc, dp};
  endfunction

  logic [W-1:0] mon_e;
  string        mon_t;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      checks++;
      assert (obs === mon_e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", mon_t, obs, mon_e);
      end
    end
  end

  // One clock cycle: drive inputs just after the edge, queue the expected vector.
  task automatic cyc(input string tag, input logic [31:0] i, input logic ir,
                     input logic dr, input logic bq, input logic bl, input logic [W-1:0] e);
    ins = i; iready = ir; dready = dr; breq = bq; brlt = bl;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    if (rst) ret_cnt = 0;
    else if (e[19]) ret_cnt++;
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic fetch_decode(input string tag, input logic [31:0] i);
    cyc({tag, "_fetch"},  i,     1'b1, 1'b0, 1'b0, 1'b0, mk(3'd0, EN_IR,   2'b00, 3'b000, DP_NONE));
    cyc({tag, "_decode"}, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd1, EN_NONE, 2'b00, 3'b000, DP_NONE));
  endtask

  initial begin
    rst = 1'b1; ins = 32'h0; iready = 1'b0; dready = 1'b0; breq = 1'b0; brlt = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    ret_cnt = 0;

    cyc("reset_idle", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd0, EN_NONE, 2'b00, 3'b000, DP_NONE));
    chk32("reset_ir", dut.ir, 32'h00000013);

    fetch_decode("add", I_ADD);
    cyc("add_exec", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd2, EN_NONE, 2'b00, 3'b000, DP_ADD));
    cyc("add_wb",   32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd4, EN_WB,   2'b01, 3'b000, DP_ADD));

    fetch_decode("lw", I_LW);
    cyc("lw_exec", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd2, EN_NONE, 2'b00, 3'b000, DP_LDI));
    for (int k = 0; k < 3; k++)
      cyc("lw_mem_wait", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd3, EN_RD, 2'b00, 3'b000, DP_LDI));
    cyc("lw_mem_done", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, mk(3'd3, EN_RD, 2'b00, 3'b000, DP_LDI));
    cyc("lw_wb",       32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd4, EN_WB, 2'b00, 3'b000, DP_LDI));

    fetch_decode("beq_t", I_BEQ);
    cyc("beq_t_exec", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, mk(3'd2, EN_BRT, 2'b00, 3'b000, DP_BEQ));
    fetch_decode("beq_nt", I_BEQ);
    cyc("beq_nt_exec", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, mk(3'd2, EN_PC, 2'b00, 3'b000, DP_BEQ));
    fetch_decode("bltu", I_BLTU);
    cyc("bltu_exec", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, mk(3'd2, EN_BRT, 2'b00, 3'b000, DP_BLTU));

    fetch_decode("jal", I_JAL);
    cyc("jal_exec", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd2, EN_NONE, 2'b00, 3'b000, DP_JAL));
    cyc("jal_wb",   32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd4, EN_JWB,  2'b11, 3'b000, DP_JAL));

    fetch_decode("addi_x0", I_ADDI);
    cyc("addi_x0_exec", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd2, EN_NONE, 2'b00, 3'b000, DP_LDI));
    cyc("addi_x0_wb",   32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd4, EN_PC,   2'b01, 3'b000, DP_LDI));

    fetch_decode("sw_abort", I_SW);
    cyc("sw_abort_exec", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd2, EN_NONE, 2'b00, 3'b000, DP_ST));
    cyc("sw_abort_mem",  32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd3, EN_WR,   2'b00, 3'b000, DP_ST));
    rst = 1'b1;
    cyc("sw_abort_rst",  32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd3, EN_WR,   2'b00, 3'b000, DP_ST));
    rst = 1'b0;
    cyc("after_abort",   32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd0, EN_NONE, 2'b00, 3'b000, DP_NONE));
    chk32("abort_ir", dut.ir, 32'h00000013);

    fetch_decode("sub", I_SUB);
    cyc("sub_exec", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd2, EN_NONE, 2'b00, 3'b000, DP_SUB));
    cyc("sub_wb",   32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd4, EN_WB,   2'b01, 3'b000, DP_SUB));
    fetch_decode("beq2", I_BEQ);
    cyc("beq2_exec", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, mk(3'd2, EN_BRT, 2'b00, 3'b000, DP_BEQ));
    fetch_decode("addi2", I_ADDI);
    cyc("addi2_exec", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd2, EN_NONE, 2'b00, 3'b000, DP_LDI));
    cyc("addi2_wb",   32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd4, EN_PC,   2'b01, 3'b000, DP_LDI));
`ifdef CTRL_RETIRE_CNT_EN
    chk32("instret_model", instret, 32'(ret_cnt));
    chk32("instret_three", instret, 32'd3);
`endif

    fetch_decode("illegal", I_ILL);
    cyc("illegal_trap", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd7, EN_NONE, 2'b00, 3'b101, DP_NONE));
    cyc("trap_hold",    I_ADD, 1'b1, 1'b1, 1'b0, 1'b0, mk(3'd7, EN_NONE, 2'b00, 3'b101, DP_NONE));
    rst = 1'b1;
    cyc("trap_rst",     32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd7, EN_NONE, 2'b00, 3'b101, DP_NONE));
    rst = 1'b0;

    fetch_decode("sw_to", I_SW);
    cyc("sw_to_exec", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd2, EN_NONE, 2'b00, 3'b000, DP_ST));
    for (int k = 0; k < 15; k++)
      cyc("sw_to_mem", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd3, EN_WR, 2'b00, 3'b000, DP_ST));
    cyc("sw_to_trap",  32'h0, 1'b0, 1'b1, 1'b0, 1'b0, mk(3'd7, EN_NONE, 2'b00, 3'b110, DP_NONE));
    rst = 1'b1;
    cyc("sw_to_rst",   32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd7, EN_NONE, 2'b00, 3'b110, DP_NONE));
    rst = 1'b0;
    cyc("final_idle",  32'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(3'd0, EN_NONE, 2'b00, 3'b000, DP_NONE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
